// File: rtl/usb_fs_tx.sv
// USB full-speed packet transmitter: SYNC, NRZI + bit-stuffed data (LSB first), EOP.
// Each line symbol is held for CLKS_PER_BIT clocks; bytes arrive on a valid/ready stream.
module usb_fs_tx #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk_48,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic       in_last,
    output logic       in_ready,
    output logic       tx_se0,
    output logic       tx_j,
    output logic       tx_en,
    output logic       busy,
    output logic       underrun
);
    localparam int TW = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {S_IDLE, S_SYNC, S_DATA, S_EOP_SE0, S_EOP_J} state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [2:0]      bit_q, bit_d;
    logic [2:0]      ones_q, ones_d;
    logic [7:0]      shift_q, shift_d;
    logic            line_q, line_d;
    logic            stuff_q, stuff_d;
    logic            last_q, last_d;
    logic            fin_q, fin_d;

    logic            tc, end_of_byte, need_byte, need_stuff, nb_val;
    logic [2:0]      nb_idx;

    // While a stuff bit is on the line, bit_q already points at the next data bit.
    assign tc          = (timer_q == TW'(CLKS_PER_BIT - 1));
    assign end_of_byte = (state_q == S_SYNC || state_q == S_DATA) && !stuff_q && (bit_q == 3'd7);
    assign need_byte   = end_of_byte && (state_q == S_SYNC || !last_q);
    assign need_stuff  = !stuff_q && (ones_q == 3'd6);
    assign nb_idx      = stuff_q ? bit_q : bit_q + 3'd1;

    always_comb begin
        nb_val = 1'b0;
        if (need_byte)
            nb_val = in_data[0];
        else if (state_q == S_SYNC)
            nb_val = (nb_idx == 3'd7);
        else
            nb_val = shift_q[nb_idx];
    end

    always_ff @(posedge clk_48) begin
        if (reset) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            bit_q   <= '0;
            ones_q  <= '0;
            shift_q <= '0;
            line_q  <= 1'b1;
            stuff_q <= 1'b0;
            last_q  <= 1'b0;
            fin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            bit_q   <= bit_d;
            ones_q  <= ones_d;
            shift_q <= shift_d;
            line_q  <= line_d;
            stuff_q <= stuff_d;
            last_q  <= last_d;
            fin_q   <= fin_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        bit_d   = bit_q;
        ones_d  = ones_q;
        shift_d = shift_q;
        line_d  = line_q;
        stuff_d = stuff_q;
        last_d  = last_q;
        fin_d   = fin_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = S_SYNC;
                    timer_d = '0;
                    bit_d   = '0;
                    ones_d  = '0;
                    stuff_d = 1'b0;
                    last_d  = 1'b0;
                    fin_d   = 1'b0;
                    line_d  = 1'b0;   // first SYNC zero toggles J to K
                end
            end
            S_SYNC, S_DATA: begin
                timer_d = tc ? '0 : timer_q + TW'(1);
                if (tc) begin
                    if (need_byte && !in_valid) begin
                        state_d = S_EOP_SE0;
                        bit_d   = '0;
                    end else if (fin_q || (end_of_byte && !need_byte && !need_stuff)) begin
                        state_d = S_EOP_SE0;
                        bit_d   = '0;
                        stuff_d = 1'b0;
                    end else begin
                        if (need_byte) begin
                            shift_d = in_data;
                            last_d  = in_last;
                            state_d = S_DATA;
                        end
                        bit_d = nb_idx;
                        if (need_stuff) begin
                            stuff_d = 1'b1;
                            line_d  = ~line_q;
                            ones_d  = '0;
                            if (end_of_byte && !need_byte)
                                fin_d = 1'b1;
                        end else begin
                            stuff_d = 1'b0;
                            line_d  = nb_val ? line_q : ~line_q;
                            ones_d  = nb_val ? ones_q + 3'd1 : 3'd0;
                        end
                    end
                end
            end
            S_EOP_SE0: begin
                timer_d = tc ? '0 : timer_q + TW'(1);
                if (tc) begin
                    if (bit_q == 3'd1) begin
                        state_d = S_EOP_J;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            S_EOP_J: begin
                timer_d = tc ? '0 : timer_q + TW'(1);
                if (tc)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        tx_en    = (state_q != S_IDLE);
        busy     = (state_q != S_IDLE);
        tx_se0   = (state_q == S_EOP_SE0);
        in_ready = tc && need_byte && in_valid;
        underrun = tc && need_byte && !in_valid;
        case (state_q)
            S_SYNC, S_DATA: tx_j = line_q;
            S_EOP_SE0:      tx_j = 1'b0;
            default:        tx_j = 1'b1;
        endcase
    end
endmodule

// File: doc/usb_fs_tx.md
Name: usb_fs_tx

Overview:
- USB full-speed (12 Mb/s) packet transmitter. It drives the tx_se0 / tx_j / tx_en line controls of the usb core.
- Takes packet bytes over a valid/ready stream and emits, on the line: SYNC, then NRZI-encoded, bit-stuffed data, LSB first, then EOP.
- Runs from the 48 MHz system clock, giving 4 clocks per bit.
- Is the transmit counterpart of the rx_j / rx_se0 receive path.

Parameters:
- CLKS_PER_BIT, 4, clocks per USB bit time. Must be ≥2.

Ports:
- clk_48  in  1  system clock, 48 MHz.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  a byte is available on in_data.
- in_data  in  8  packet byte, sent LSB first.
- in_last  in  1  qualifies in_data as the final byte of the packet.
- in_ready  out  1  one-cycle pulse; the byte is consumed on this cycle.
- tx_se0  out  1  drive SE0 (both lines low).
- tx_j  out  1  drive J when 1, K when 0; don't-care while tx_se0=1.
- tx_en  out  1  output enable for the D+/D- drivers.
- busy  out  1  high whenever state ≠ IDLE.
- underrun  out  1  one-cycle pulse when a byte was due but in_valid was low.

Behaviour:
- One clock domain. There are one-clock-per-bit-time requirements only where stated.
- Reset is synchronous, active-high. It applies on the next clk_48 edge, including mid-packet, and sets:
  - state=IDLE, tx_en=0, tx_j=1, tx_se0=0;
  - in_ready=0, underrun=0, busy=0;
  - bit counter, ones counter and shift register to 0.
  - No EOP is emitted after a reset abort.
- Bit timer:
  - counts 0..CLKS_PER_BIT-1 while state ≠ IDLE;
  - each line symbol is held for exactly CLKS_PER_BIT cycles;
  - state and bit advance on the terminal count.
- States: IDLE → SYNC → DATA → EOP_SE0 → EOP_J → IDLE.
- IDLE:
  - outputs at idle values;
  - in_valid=1 moves to SYNC on the next edge, so tx_en rises 1 cycle after in_valid is first seen;
  - the pending byte is not consumed yet.
- SYNC:
  - sends bit pattern 0000_0001 through the NRZI encoder;
  - the line starts from J, giving KJKJKJKK;
  - the final 1 counts toward the stuffing ones-run (run=1 on leaving SYNC).
- Byte load:
  - happens on the terminal-count cycle of bit 7 of SYNC or of the current byte;
  - if in_valid=1: in_ready pulses that cycle, and in_data and in_last are captured;
  - if in_valid=0 and the current byte was not last: underrun pulses and the next state is EOP_SE0;
  - after a byte flagged last: no load, and the next state is EOP_SE0 once any pending stuff bit is sent.
- NRZI encoding:
  - data bit 0 toggles the line (tx_j inverts);
  - data bit 1 holds the line.
- Bit stuffing:
  - after 6 consecutive transmitted 1s, insert one 0 bit (a toggle) before the next data bit;
  - a stuffed bit does not consume data and resets the run to 0;
  - any 0 resets the run;
  - stuffing applies across byte boundaries;
  - stuffing applies after the final bit, so a stuff bit precedes the EOP when the run hits 6 on the last bit.
- EOP_SE0: tx_se0=1, tx_j=0, held 2 bit times.
- EOP_J: tx_se0=0, tx_j=1, held 1 bit time.
- Return to IDLE: tx_en=0 on the next edge. There is a minimum of 1 IDLE cycle before a new SYNC.
- tx_en stays high continuously from SYNC through EOP_J.
- in_ready pulses never occur in IDLE, EOP_SE0 or EOP_J.
- in_data must be held stable while in_valid=1 and in_ready=0. A drop of in_valid is sampled only at load points.

Test Plan:
- Single byte 0x00 with in_last=1:
  - line symbols are K J K J K J K K, then J K J K J K J K, then SE0 SE0 J;
  - tx_en is high for 76 cycles;
  - in_ready pulses once, on cycle 32 after tx_en rises (the last clock of SYNC).
- Single byte 0xFF, last:
  - after SYNC the line holds K for 5 bits, then a stuffed J, then J for 3 bits;
  - the byte occupies 9 bit times, so tx_en is high for 80 cycles.
- Back-to-back bytes 0xA5 then 0x3C (in_last on 0x3C), with in_valid held high:
  - exactly 2 in_ready pulses, 32 cycles apart;
  - line bits match the NRZI of LSB-first data;
  - no stuff bits occur.
- Underrun: byte 0x12 with in_last=0, then in_valid deasserted:
  - underrun pulses on the bit-7 terminal cycle;
  - EOP follows immediately;
  - no second in_ready.
- Reset asserted during DATA bit 3:
  - next edge gives tx_en=0, tx_j=1, busy=0, with no EOP;
  - a subsequent packet starts with a clean SYNC and run=0.
- Stuff across boundary and before EOP: bytes 0xF0, 0xFF (last):
  - the stuff bit lands between bits 1 and 2 of 0xFF;
  - after bit 7 the run reaches 6 and a stuff bit is sent before SE0.
